// File: rtl/matmul_operand_feeder.sv
// rtl/matmul_operand_feeder.sv - skewed operand feeder for a DIM x DIM systolic MAC grid
module matmul_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic                      wr_sel_i,
  input  logic [$clog2(DIM)-1:0]    wr_row_i,
  input  logic [$clog2(DIM)-1:0]    wr_col_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  input  logic                      go_i,
  output logic [DIM*DATA_WIDTH-1:0] a_o,
  output logic [DIM*DATA_WIDTH-1:0] b_o,
  output logic                      start_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      wr_drop_o
);
  localparam int IDX_W = $clog2(DIM);
  localparam int KW    = $clog2(3*DIM-2);
  localparam logic [KW-1:0]  K_LAST = KW'(3*DIM-3);
  localparam logic [IDX_W:0] DIM_L  = (IDX_W+1)'(DIM);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DATA_WIDTH-1:0]  a_buf [DIM][DIM];
  logic [DATA_WIDTH-1:0]  b_buf [DIM][DIM];
  logic [DIM*DATA_WIDTH-1:0] a_d, b_d;
  logic                   wr_in_range, wr_open, wr_ok;

  always_comb begin
    wr_in_range = ({1'b0, wr_row_i} < DIM_L) && ({1'b0, wr_col_i} < DIM_L);
    wr_open     = (state_q == IDLE) || (state_q == HOLD);
    wr_ok       = wr_en_i && wr_open && wr_in_range;
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE:  if (go_i) state_d = CLEAR;
      CLEAR: begin
        state_d = FEED;
        k_d     = '0;
      end
      FEED: begin
        if (k_q == K_LAST) begin
          state_d = HOLD;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      HOLD:  if (go_i) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so operands are computed for the upcoming cycle's k.
  // Lane i carries A[i][e] and lane j carries B[e][j] when k = lane + e.
  always_comb begin
    a_d = '0;
    b_d = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < DIM; i++) begin
        for (int e = 0; e < DIM; e++) begin
          if (k_d == KW'(i + e)) begin
            a_d[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[i][e];
            b_d[i*DATA_WIDTH +: DATA_WIDTH] = b_buf[e][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_q       <= '0;
      a_o       <= '0;
      b_o       <= '0;
      start_o   <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wr_drop_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      a_o       <= a_d;
      b_o       <= b_d;
      start_o   <= (state_d == FEED) || (state_d == HOLD);
      busy_o    <= (state_d == CLEAR) || (state_d == FEED);
      done_o    <= (state_q == FEED) && (state_d == HOLD);
      wr_drop_o <= wr_en_i && !wr_ok;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      if (wr_sel_i) b_buf[wr_row_i][wr_col_i] <= wr_data_i;
      else          a_buf[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

endmodule
